// File: rtl/hv_flip_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : hv_flip_counter_if
//  Brief    : Start/busy/done handshake and data bundle for hv_flip_counter.
//             Optional thresh/exceeds pair present when FLIP_THRESH_EN is
//             defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface hv_flip_counter_if #(
  parameter int DIM   = 1024,
  parameter int CNT_W = $clog2(DIM + 1)
);

  logic             start;
  logic [DIM-1:0]   ref_vec;
  logic [DIM-1:0]   noisy_vec;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] distance;
`ifdef FLIP_THRESH_EN
  logic [CNT_W-1:0] thresh;
  logic             exceeds;
`endif

  // Requester side: issues operations and observes results
  modport master (
    output start,
    output ref_vec,
    output noisy_vec,
`ifdef FLIP_THRESH_EN
    output thresh,
    input  exceeds,
`endif
    input  busy,
    input  done,
    input  distance
  );

  // Counter side
  modport slave (
    input  start,
    input  ref_vec,
    input  noisy_vec,
`ifdef FLIP_THRESH_EN
    input  thresh,
    output exceeds,
`endif
    output busy,
    output done,
    output distance
  );

endinterface : hv_flip_counter_if
`default_nettype wire

// File: rtl/hv_flip_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hv_flip_counter
//  Brief    : Hamming distance between a clean hypervector and its noisy
//             copy. The XOR is captured on start and popcounted one
//             CHUNK-bit slice per cycle; the total is reported with a
//             one-cycle done pulse.
//             Optional macro FLIP_THRESH_EN adds a thresh input and a
//             registered exceeds flag (final sum > thresh).
//  Revision : 1.0 - initial release
// ============================================================================
module hv_flip_counter #(
  parameter int DIM   = 1024,
  parameter int CHUNK = 64,
  parameter int CNT_W = $clog2(DIM + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  hv_flip_counter_if.slave   bus
);

  localparam int c_nchunk = DIM / CHUNK;
  localparam int c_pop_w  = $clog2(CHUNK + 1);
  localparam int c_idx_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_idx_w-1:0]   r_idx;
  logic [CNT_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_distance;
  logic [DIM-1:0]       r_diff;
  logic                 r_done;
`ifdef FLIP_THRESH_EN
  logic                 r_exceeds;
`endif

  logic                 w_accept;
  logic                 w_last;
  logic [CHUNK-1:0]     w_chunk;
  logic [c_pop_w-1:0]   w_pop;
  logic [CNT_W-1:0]     w_sum;

  function automatic logic [c_pop_w-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [c_pop_w-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + c_pop_w'(v[i]);
    end
    return cnt;
  endfunction

  // A start is honoured in IDLE and DONE; while counting it is ignored
  assign w_accept = bus.start && (r_state != S_BUSY);
  assign w_last   = (r_state == S_BUSY) && (r_idx == c_idx_w'(c_nchunk - 1));
  assign w_chunk  = r_diff[r_idx*CHUNK +: CHUNK];
  assign w_pop    = popcount(w_chunk);
  assign w_sum    = r_acc + CNT_W'(w_pop);

  assign bus.busy     = (r_state == S_BUSY);
  assign bus.done     = r_done;
  assign bus.distance = r_distance;
`ifdef FLIP_THRESH_EN
  assign bus.exceeds  = r_exceeds;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_BUSY;
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture XOR on accept, accumulate one slice per cycle, publish on last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_diff     <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_distance <= '0;
      r_done     <= 1'b0;
`ifdef FLIP_THRESH_EN
      r_exceeds  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_diff <= bus.ref_vec ^ bus.noisy_vec;
        r_idx  <= '0;
        r_acc  <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc <= w_sum;
        r_idx <= r_idx + c_idx_w'(1);
        if (w_last) begin
          // distance only ever changes here, so no partial sum is visible
          r_distance <= w_sum;
          r_done     <= 1'b1;
`ifdef FLIP_THRESH_EN
          r_exceeds  <= (w_sum > bus.thresh);
`else
          // no threshold flag in this build
`endif
        end
      end
    end
  end

endmodule : hv_flip_counter
`default_nettype wire
